// File: rtl/cassette_port.sv
// Cassette/sound I/O port: one Z80 port driving a 1-bit sigma-delta DAC, the
// motor relay and the 32-column mode, and flagging rising edges on cas_in.
module cassette_port #(
  parameter logic [7:0]  PORT_ADDR   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2      // must be >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_m1_n,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] port_dout,
  output logic       port_cs_n,
  input  logic       cas_in,
  output logic       audio_out,
  output logic       motor_on,
  output logic       mode32
);

  localparam int unsigned PCM_W = 8;
  localparam int unsigned ACC_W = PCM_W + 1;

  logic                   io_sel;
  logic                   wr_act;
  logic                   wr_idle_q;
  logic                   wr_strobe;
  logic [1:0]             level;
  logic [PCM_W-1:0]       pcm;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cas_rise;
  logic                   cas_flag;
  logic                   unused_ok;

  // Acknowledge cycles (M1 low) never select the port.
  assign io_sel = !cpu_iorq_n && cpu_m1_n && (cpu_addr == PORT_ADDR);
  assign wr_act = io_sel && !cpu_wr_n;

  // wr_idle_q remembers that wr_act was low last clock; it resets to 0 so a
  // write already in flight when reset releases is not seen as a new edge.
  assign wr_strobe = wr_act && wr_idle_q;

  assign cas_rise = sync_q[SYNC_STAGES-2] && !sync_q[SYNC_STAGES-1];

  assign port_cs_n = !(io_sel && !cpu_rd_n);
  assign port_dout = {cas_flag, mode32, 6'b000000};

  always_comb begin
    pcm = 8'h80;
    unique case (level)
      2'b01:   pcm = 8'hE0;
      2'b10:   pcm = 8'h20;
      default: pcm = 8'h80;
    endcase
  end

  // acc[8] holds the registered carry, which is the PDM output itself.
  assign acc_sum   = {1'b0, acc[PCM_W-1:0]} + {1'b0, pcm};
  assign audio_out = acc[ACC_W-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idle_q <= 1'b0;
      level     <= 2'b00;
      motor_on  <= 1'b0;
      mode32    <= 1'b0;
      cas_flag  <= 1'b0;
      acc       <= '0;
      sync_q    <= '0;
    end else begin
      wr_idle_q <= !wr_act;
      acc       <= acc_sum;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], cas_in};
      if (wr_strobe) begin
        level    <= cpu_dout[1:0];
        motor_on <= cpu_dout[2];
        mode32   <= cpu_dout[3];
      end
      // Set beats clear when an edge and a write land on the same clock.
      if (cas_rise && motor_on)
        cas_flag <= 1'b1;
      else if (wr_strobe)
        cas_flag <= 1'b0;
    end
  end

  assign unused_ok = ^cpu_dout[7:4];

endmodule

// File: tb/tb_cassette_port.sv
// Directed bench for cassette_port: port writes/reads, cassette edge flag,
// decode qualification, sigma-delta duty and reset behaviour.
module tb_cassette_port;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic [7:0] cpu_addr, cpu_dout;
  logic [7:0] port_dout;
  logic       port_cs_n;
  logic       cas_in;
  logic       audio_out, motor_on, mode32;

  int checks = 0;
  int errors = 0;

  cassette_port #(.PORT_ADDR(8'hFF), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_m1_n   (cpu_m1_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .port_dout  (port_dout),
    .port_cs_n  (port_cs_n),
    .cas_in     (cas_in),
    .audio_out  (audio_out),
    .motor_on   (motor_on),
    .mode32     (mode32)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_m1_n   = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cpu_m1_n   = 1'b1;
    cpu_addr   = addr;
    cpu_dout   = data;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    bus_write(addr, data);
    tick();
    bus_idle();
    tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] cnt;
    reset    = 1'b1;
    cas_in   = 1'b0;
    cpu_addr = 8'h00;
    cpu_dout = 8'h00;
    bus_idle();
    repeat (3) tick();
    check("rst_dout",  port_dout, 8'h00);
    check("rst_cs_n",  port_cs_n, 8'h01);
    check("rst_audio", audio_out, 8'h00);
    check("rst_motor", motor_on,  8'h00);
    check("rst_mode",  mode32,    8'h00);
    reset = 1'b0;
    tick();

    // OUT (FF),05 held 3 clocks; a cas edge lands mid-hold, so a repeated strobe would clear it
    cas_in = 1'b1;
    bus_write(8'hFF, 8'h05);
    repeat (3) tick();
    bus_idle();
    tick();
    check("wr_motor",      motor_on,  8'h01);
    check("wr_mode32",     mode32,    8'h00);
    check("wr_one_strobe", port_dout, 8'h80);
    tick();
    cnt = 8'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 8'(audio_out);
      tick();
    end
    check("duty_e0", cnt, 8'd14);

    // Read test: clear flag, fresh edge, IN A,(FF)
    cas_in = 1'b0;
    io_write(8'hFF, 8'h05);
    repeat (3) tick();
    check("rd_cleared", port_dout, 8'h00);
    cas_in = 1'b1;
    repeat (3) tick();
    cpu_iorq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_addr   = 8'hFF;
    #1;
    check("rd_cs_n", port_cs_n, 8'h00);
    check("rd_dout", port_dout, 8'h80);
    tick();
    bus_idle();
    #1;
    check("rd_cs_idle", port_cs_n, 8'h01);
    check("rd_no_side", port_dout, 8'h80);
    io_write(8'hFF, 8'h04);
    check("rd_wr_clear", port_dout, 8'h00);

    // Motor off: edges ignored
    io_write(8'hFF, 8'h00);
    check("moff_motor", motor_on, 8'h00);
    cas_in = 1'b0;
    repeat (3) tick();
    cas_in = 1'b1;
    repeat (3) tick();
    cas_in = 1'b0;
    repeat (3) tick();
    check("moff_flag", port_dout, 8'h00);

    // Collision: edge detect and strobe on the same clock
    io_write(8'hFF, 8'h04);
    repeat (3) tick();
    cas_in = 1'b1;
    tick();
    bus_write(8'hFF, 8'h04);
    tick();
    bus_idle();
    tick();
    check("collide_flag", port_dout, 8'h80);

    // Decode: acknowledge cycle at FF and write to FE are ignored
    cpu_iorq_n = 1'b0;
    cpu_m1_n   = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_wr_n   = 1'b0;
    cpu_addr   = 8'hFF;
    cpu_dout   = 8'h08;
    #1;
    check("ack_cs_n", port_cs_n, 8'h01);
    tick();
    bus_idle();
    tick();
    check("ack_dout",  port_dout, 8'h80);
    check("ack_motor", motor_on,  8'h01);
    io_write(8'hFE, 8'h08);
    check("fe_dout",  port_dout, 8'h80);
    check("fe_motor", motor_on,  8'h01);
    cpu_iorq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_addr   = 8'hFE;
    #1;
    check("fe_cs_n", port_cs_n, 8'h01);
    bus_idle();

    // mode32 write also clears the flag
    io_write(8'hFF, 8'h08);
    check("m32_dout",  port_dout, 8'h40);
    check("m32_motor", motor_on,  8'h00);

    // Reset mid-write with level=10; write still held across reset release
    bus_write(8'hFF, 8'h0E);
    tick();
    check("pre_rst_motor", motor_on, 8'h01);
    check("pre_rst_mode",  mode32,   8'h01);
    reset = 1'b1;
    tick();
    check("mrst_motor", motor_on,  8'h00);
    check("mrst_mode",  mode32,    8'h00);
    check("mrst_dout",  port_dout, 8'h00);
    check("mrst_audio", audio_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_audio_hold", audio_out, 8'h00);
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("post_rst_toggle", audio_out, 8'((i % 2) == 0));
    end
    check("post_rst_motor", motor_on, 8'h00);
    check("post_rst_mode",  mode32,   8'h00);
    bus_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cassette_port.md
CASSETTE_PORT -- requirements
Module: cassette_port

Interface
REQ-001 SHALL provide parameter PORT_ADDR, default 8'hFF, giving the Z80 I/O port decoded by this block.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, giving the synchronizer depth on cas_in (minimum 2).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clock, input, 1 bit: CPU clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port cpu_iorq_n, input, 1 bit: Z80 IORQ, active low.
REQ-007 SHALL have port cpu_rd_n, input, 1 bit: Z80 RD, active low.
REQ-008 SHALL have port cpu_wr_n, input, 1 bit: Z80 WR, active low.
REQ-009 SHALL have port cpu_m1_n, input, 1 bit: Z80 M1, active low.
REQ-010 SHALL have port cpu_addr, input, 8 bits: low byte of the CPU address.
REQ-011 SHALL have port cpu_dout, input, 8 bits: CPU write data.
REQ-012 SHALL have port port_dout, output, 8 bits: read data to the glue mux.
REQ-013 SHALL have port port_cs_n, output, 1 bit: active low while a read of PORT_ADDR is in progress.
REQ-014 SHALL have port cas_in, input, 1 bit: asynchronous cassette input.
REQ-015 SHALL have port audio_out, output, 1 bit: registered sigma-delta PDM, driving AUDIO_L/AUDIO_R.
REQ-016 SHALL have port motor_on, output, 1 bit: cassette motor relay state.
REQ-017 SHALL have port mode32, output, 1 bit: 32-character video mode, routed to the video block.

Function
REQ-018 SHALL define io_sel as (cpu_iorq_n=0 and cpu_m1_n=1 and cpu_addr=PORT_ADDR); cycles with cpu_m1_n=0 are interrupt acknowledges and SHALL be ignored.
REQ-019 SHALL detect a write from the registered previous value of wr_act = (io_sel and cpu_wr_n=0): exactly one write strobe on its 0->1 transition, regardless of how long WR is held.
REQ-020 On the write strobe, SHALL latch level[1:0]=cpu_dout[1:0], motor_on=cpu_dout[2] and mode32=cpu_dout[3]; these take effect 1 clock after the strobe.
REQ-021 SHALL map level combinationally to the PCM value: 01->8'hE0, 10->8'h20, 00->8'h80, 11->8'h80.
REQ-022 SHALL implement a first-order sigma-delta: a 9-bit accumulator acc updated every clock as acc <= {1'b0,acc[7:0]} + pcm, with audio_out <= carry out of that sum (registered).
REQ-023 With pcm=8'h80 steady, audio_out SHALL toggle with a 50% duty cycle.
REQ-024 With pcm=8'hE0, audio_out SHALL be high 7 clocks in every 8; with pcm=8'h20, high 1 clock in every 8.
REQ-025 SHALL pass cas_in through a SYNC_STAGES flip-flop synchronizer and detect a rising edge from the last two synchronized stages.
REQ-026 A synchronized rising edge while motor_on=1 SHALL set cas_flag; while motor_on=0, edges SHALL be ignored.
REQ-027 The write strobe SHALL clear cas_flag.
REQ-028 If a set and a clear of cas_flag occur in the same clock, set SHALL win.
REQ-029 port_cs_n SHALL be combinational: 0 iff io_sel and cpu_rd_n=0, otherwise 1.
REQ-030 port_dout SHALL be combinational {cas_flag, mode32, 6'b000000} at all times.
REQ-031 Reads SHALL have no side effects.
REQ-032 Address bits other than cpu_addr[7:0] SHALL be don't-care.

Reset
REQ-033 While reset=1 at a clock edge, the following SHALL clear: level=00, motor_on=0, mode32=0, cas_flag=0, acc=0, audio_out=0, the synchronizer stages, and the write-detect register.
REQ-034 Reset SHALL take priority over any concurrent write strobe or cas edge.
REQ-035 A write cycle spanning reset deassertion SHALL NOT produce a strobe if wr_act is already 1 on the first clock after reset; a wr_act that is already 1 at that point is not a 0->1 transition.

Verification
REQ-036 Write test: OUT (FFh),05h with WR held 3 clocks -> one strobe, level=01, motor_on=1, mode32=0, audio_out 7-of-8 duty.
REQ-037 Read test: motor_on=1, one cas_in rising edge, then IN A,(FFh) -> port_cs_n=0 during the read, port_dout=8'h80; next OUT (FFh),04h -> port_dout=8'h00.
REQ-038 Motor-off test: motor_on=0, pulse cas_in -> cas_flag stays 0 and port_dout[7]=0.
REQ-039 Collision test: cas edge reaches the edge detector on the same clock as the write strobe -> cas_flag=1 afterwards.
REQ-040 Decode test: an M1+IORQ acknowledge cycle at address FFh, and an OUT to port FEh -> no state change, port_cs_n stays 1.
REQ-041 Reset test: assert reset mid-write with level=10 -> all outputs zero next clock; audio_out stays 0 until reset releases, then a 50% toggle at pcm 8'h80.
